exec_issue_ctrl: RTL and testbench

//  Sequences the RV32I execute stage: owns the decode->execute issue handshake, inserts bubbles
//  (drives execute Noop) for load-use hazards and CSR drains, and turns taken branches/jumps from

---
 rtl/exec_issue_ctrl_pkg.sv | 23 ++
 rtl/exec_issue_ctrl_if.sv | 38 +++
 rtl/exec_issue_ctrl_hazard.sv | 23 ++
 rtl/exec_issue_ctrl.sv | 146 ++++++++++++++
 tb/tb_exec_issue_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/exec_issue_ctrl_pkg.sv
// Shared types and widths for the RV32I execute-stage issue controller.
package exec_issue_ctrl_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned REG_W = 5;
   localparam int unsigned CNT_W = 3;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_FLUSH,
      ST_CSR_DRAIN,
      ST_HALT
   } state_t;

   // Instruction currently held in the execute register
   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             is_load;
      logic             is_halt;
   } ex_rec_t;

endpackage

// File: rtl/exec_issue_ctrl_if.sv
// Decode/execute/fetch-facing signals of the issue controller.
interface exec_issue_ctrl_if;
   import exec_issue_ctrl_pkg::*;

   logic             dec_valid;
   logic             dec_ready;
   logic [REG_W-1:0] dec_rd;
   logic [REG_W-1:0] dec_rs1;
   logic [REG_W-1:0] dec_rs2;
   logic             dec_use_rs1;
   logic             dec_use_rs2;
   logic             dec_is_load;
   logic             dec_is_csr;
   logic             dec_is_halt;
   logic             ex_branch_tkn;
   logic             ex_jump;
   logic [XLEN-1:0]  ex_target;
   logic             ex_en;
   logic             ex_noop;
   logic             redirect_vld;
   logic [XLEN-1:0]  redirect_pc;
   logic             flush;
   logic             halt;
   logic [31:0]      stall_cnt;

   modport master (
      output dec_valid, dec_rd, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
             dec_is_load, dec_is_csr, dec_is_halt, ex_branch_tkn, ex_jump, ex_target,
      input  dec_ready, ex_en, ex_noop, redirect_vld, redirect_pc, flush, halt, stall_cnt
   );

   modport slave (
      input  dec_valid, dec_rd, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
             dec_is_load, dec_is_csr, dec_is_halt, ex_branch_tkn, ex_jump, ex_target,
      output dec_ready, ex_en, ex_noop, redirect_vld, redirect_pc, flush, halt, stall_cnt
   );

endinterface

// File: rtl/exec_issue_ctrl_hazard.sv
// Load-use detector: offered instruction reads the register a load in execute writes.
module exec_issue_ctrl_hazard
   import exec_issue_ctrl_pkg::*;
(
   input  logic             ex_valid,
   input  logic             ex_is_load,
   input  logic [REG_W-1:0] ex_rd,
   input  logic [REG_W-1:0] rs1,
   input  logic [REG_W-1:0] rs2,
   input  logic             use_rs1,
   input  logic             use_rs2,
   output logic             hazard
);

   logic rs1_hit;
   logic rs2_hit;

   // x0 is hardwired, so a load targeting it never produces a dependency
   assign rs1_hit = use_rs1 && (rs1 == ex_rd);
   assign rs2_hit = use_rs2 && (rs2 == ex_rd);
   assign hazard  = ex_valid && ex_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/exec_issue_ctrl.sv
// Execute-stage issue controller: issue handshake, load-use/CSR bubbles, redirect+flush, halt.
module exec_issue_ctrl
   import exec_issue_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CSR_DRAIN    = 2
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   exec_issue_ctrl_if.slave   bus
);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   ex_rec_t          ex;
   logic             hazard;
   logic             redirect;
   logic             ready;
   logic             issue;
   logic             flush;
   logic             redirect_vld;
   logic [31:0]      stall_cnt;

   exec_issue_ctrl_hazard u_hazard (
      .ex_valid   (ex.valid),
      .ex_is_load (ex.is_load),
      .ex_rd      (ex.rd),
      .rs1        (bus.dec_rs1),
      .rs2        (bus.dec_rs2),
      .use_rs1    (bus.dec_use_rs1),
      .use_rs2    (bus.dec_use_rs2),
      .hazard     (hazard)
   );

   assign redirect = ex.valid && (bus.ex_branch_tkn || bus.ex_jump);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state <= ST_RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         ST_RUN: begin
            if (redirect) begin
               state_nxt = ST_FLUSH;
               cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
            end else if (ex.valid && ex.is_halt) begin
               state_nxt = ST_HALT;
            end else if (issue && bus.dec_is_csr) begin
               state_nxt = ST_CSR_DRAIN;
               cnt_nxt   = CNT_W'(CSR_DRAIN - 1);
            end
         end
         ST_FLUSH: begin
            if (cnt == '0) state_nxt = ST_RUN;
            else           cnt_nxt   = cnt - 1'b1;
         end
         ST_CSR_DRAIN: begin
            if (redirect) begin
               state_nxt = ST_FLUSH;
               cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
            end else if (cnt == '0) begin
               state_nxt = ST_RUN;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_HALT: state_nxt = ST_HALT;
         default: state_nxt = ST_RUN;
      endcase
   end

   // Redirect cycle holds the offered instruction; the flush makes decode drop it
   always_comb begin
      ready        = 1'b0;
      issue        = 1'b0;
      flush        = 1'b0;
      redirect_vld = 1'b0;
      unique case (state)
         ST_RUN: begin
            if (redirect) begin
               flush        = 1'b1;
               redirect_vld = 1'b1;
            end else if (!(ex.valid && ex.is_halt) && !hazard) begin
               ready = 1'b1;
               issue = bus.dec_valid;
            end
         end
         ST_FLUSH: begin
            flush = 1'b1;
            ready = 1'b1;
         end
         ST_CSR_DRAIN: begin
            if (redirect) begin
               flush        = 1'b1;
               redirect_vld = 1'b1;
            end
         end
         default: begin
            ready = 1'b0;
         end
      endcase
      if (!i_rst_n) begin
         ready = 1'b0;
         issue = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         ex <= '0;
      end else if (issue) begin
         ex.valid   <= 1'b1;
         ex.rd      <= bus.dec_rd;
         ex.is_load <= bus.dec_is_load;
         ex.is_halt <= bus.dec_is_halt;
      end else begin
         ex.valid <= 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n)                       stall_cnt <= '0;
      else if (bus.dec_valid && !ready)   stall_cnt <= stall_cnt + 32'd1;
   end

   assign bus.dec_ready    = ready;
   assign bus.ex_en        = issue;
   assign bus.ex_noop      = ~ex.valid;
   assign bus.redirect_vld = redirect_vld;
   assign bus.redirect_pc  = bus.ex_target & ~XLEN'(1);
   assign bus.flush        = flush;
   assign bus.halt         = (state == ST_HALT);
   assign bus.stall_cnt    = stall_cnt;

endmodule

// File: tb/tb_exec_issue_ctrl.sv
// Randomized scoreboard bench for exec_issue_ctrl against a cycle-budget reference model.
module tb_exec_issue_ctrl;

   localparam int unsigned FLUSH_N = 2;
   localparam int unsigned DRAIN_N = 2;
   localparam int unsigned CYCLES  = 4000;

   typedef struct {
      bit          rst_cycle;
      bit          ready;
      bit          en;
      bit          noop;
      bit          rvld;
      bit          flush;
      bit          halt;
      logic [31:0] pc;
      logic [31:0] stall;
   } exp_t;

   logic clk;
   logic rst_n;
   exec_issue_ctrl_if bus_if ();

   exp_t q[$];
   int unsigned tests = 0;
   int unsigned fails = 0;

   exec_issue_ctrl #(.FLUSH_CYCLES(FLUSH_N), .CSR_DRAIN(DRAIN_N)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, want);
      end
   endtask

   // Monitor: compares whatever the DUT presents mid-cycle with the queued expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("dec_ready", 32'(bus_if.dec_ready), 32'(e.ready));
            check("ex_en", 32'(bus_if.ex_en), 32'(e.en));
            if (!e.rst_cycle) begin
               check("ex_noop", 32'(bus_if.ex_noop), 32'(e.noop));
               check("redirect_vld", 32'(bus_if.redirect_vld), 32'(e.rvld));
               check("flush", 32'(bus_if.flush), 32'(e.flush));
               check("halt", 32'(bus_if.halt), 32'(e.halt));
               check("stall_cnt", bus_if.stall_cnt, e.stall);
               if (e.rvld) check("redirect_pc", bus_if.redirect_pc, e.pc);
            end
         end
      end
   end

   // Reference model: what sits in execute, and how many cycles of flush/drain remain
   bit          m_ex_valid;
   logic [4:0]  m_ex_rd;
   bit          m_ex_load;
   bit          m_ex_halt;
   int          flush_left;
   int          drain_left;
   bit          halted;
   logic [31:0] m_stall;

   task automatic model_reset();
      m_ex_valid = 0;
      m_ex_rd    = '0;
      m_ex_load  = 0;
      m_ex_halt  = 0;
      flush_left = 0;
      drain_left = 0;
      halted     = 0;
      m_stall    = '0;
   endtask

   initial begin
      exp_t e;
      bit   prev_hold;
      bit   redir;
      bit   ld_use;
      int   halted_cycles;

      model_reset();
      prev_hold     = 0;
      halted_cycles = 0;
      rst_n = 1'b0;
      bus_if.dec_valid     = 1'b0;
      bus_if.dec_rd        = '0;
      bus_if.dec_rs1       = '0;
      bus_if.dec_rs2       = '0;
      bus_if.dec_use_rs1   = 1'b0;
      bus_if.dec_use_rs2   = 1'b0;
      bus_if.dec_is_load   = 1'b0;
      bus_if.dec_is_csr    = 1'b0;
      bus_if.dec_is_halt   = 1'b0;
      bus_if.ex_branch_tkn = 1'b0;
      bus_if.ex_jump       = 1'b0;
      bus_if.ex_target     = '0;

      for (int unsigned cyc = 0; cyc < CYCLES; cyc++) begin
         @(posedge clk);
         #1;
         rst_n = (cyc < 2 || halted_cycles > 4 || $urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
         if (!prev_hold || !rst_n) begin
            bus_if.dec_valid   = ($urandom_range(0, 99) < 80);
            bus_if.dec_rd      = 5'($urandom_range(0, 3));
            bus_if.dec_rs1     = 5'($urandom_range(0, 3));
            bus_if.dec_rs2     = 5'($urandom_range(0, 3));
            bus_if.dec_use_rs1 = ($urandom_range(0, 99) < 70);
            bus_if.dec_use_rs2 = ($urandom_range(0, 99) < 50);
            bus_if.dec_is_load = ($urandom_range(0, 99) < 35);
            bus_if.dec_is_csr  = ($urandom_range(0, 99) < 6);
            bus_if.dec_is_halt = ($urandom_range(0, 99) < 3);
         end
         bus_if.ex_branch_tkn = ($urandom_range(0, 99) < 10);
         bus_if.ex_jump       = ($urandom_range(0, 99) < 5);
         bus_if.ex_target     = $urandom;
         #1;

         e = '{rst_cycle: 0, ready: 0, en: 0, noop: 0, rvld: 0, flush: 0, halt: 0, pc: '0, stall: '0};
         if (!rst_n) begin
            e.rst_cycle = 1;
            q.push_back(e);
            model_reset();
            prev_hold     = 0;
            halted_cycles = 0;
            continue;
         end

         redir  = m_ex_valid && (bus_if.ex_branch_tkn || bus_if.ex_jump);
         ld_use = m_ex_valid && m_ex_load && (m_ex_rd != 0) &&
                  ((bus_if.dec_use_rs1 && bus_if.dec_rs1 == m_ex_rd) ||
                   (bus_if.dec_use_rs2 && bus_if.dec_rs2 == m_ex_rd));
         e.noop  = !m_ex_valid;
         e.halt  = halted;
         e.stall = m_stall;
         e.pc    = {bus_if.ex_target[31:1], 1'b0};
         if (halted) begin
            e.ready = 0;
         end else if (flush_left > 0) begin
            e.flush = 1;
            e.ready = 1;
         end else if (redir) begin
            e.rvld  = 1;
            e.flush = 1;
         end else if (drain_left > 0 || (m_ex_valid && m_ex_halt) || ld_use) begin
            e.ready = 0;
         end else begin
            e.ready = 1;
            e.en    = bus_if.dec_valid;
         end
         q.push_back(e);

         if (bus_if.dec_valid && !e.ready) m_stall = m_stall + 32'd1;
         if (halted) begin
            halted_cycles++;
         end else if (flush_left > 0) begin
            flush_left--;
         end else if (redir) begin
            flush_left = FLUSH_N;
            drain_left = 0;
         end else if (drain_left > 0) begin
            drain_left--;
         end else if (m_ex_valid && m_ex_halt) begin
            halted = 1;
         end
         if (e.en && bus_if.dec_is_csr) drain_left = DRAIN_N;
         m_ex_valid = e.en;
         if (e.en) begin
            m_ex_rd   = bus_if.dec_rd;
            m_ex_load = bus_if.dec_is_load;
            m_ex_halt = bus_if.dec_is_halt;
         end
         prev_hold = bus_if.dec_valid && !e.ready;
      end

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
